// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ILEN_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  // Canonical NOP the core substitutes while inst_valid is low.
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries. Flush wins over push; push and pop may
// happen together at any occupancy, including full.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  fetch_entry_t            push_entry,
  input  logic                    pop,
  input  logic                    flush,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output fetch_entry_t            head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] wr_ptr_d;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] rd_ptr_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          do_push_s;
  logic          do_pop_s;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == {CW{1'b0}});
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
    if (flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + PW'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  // State registers; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/inst_fetch_queue_chk.sv
// Invariant and protocol checks for the fetch queue counters.
module inst_fetch_queue_chk #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          mem_rsp_valid,
  input logic          push,
  input logic          pop,
  input logic          fifo_full,
  input logic [CW-1:0] outstanding,
  input logic [CW-1:0] drop_cnt,
  input logic [CW-1:0] occupancy
);

  a_drop_le_outstanding: assert property (@(posedge clk) disable iff (!rst)
    drop_cnt <= outstanding);

  a_outstanding_le_depth: assert property (@(posedge clk) disable iff (!rst)
    outstanding <= CW'(DEPTH));

  a_occ_plus_out_le_depth: assert property (@(posedge clk) disable iff (!rst)
    ({1'b0, occupancy} + {1'b0, outstanding}) <= (CW+1)'(DEPTH));

  a_rsp_needs_outstanding: assert property (@(posedge clk) disable iff (!rst)
    mem_rsp_valid |-> (outstanding != {CW{1'b0}}));

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    (push & fifo_full) |-> pop);

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: issues sequential word reads, buffers returned instructions
// with their PCs, and handles core redirects by flushing and dropping the
// responses of requests already in flight.
module inst_fetch_queue #(
  parameter int unsigned          DEPTH    = 4,
  parameter int unsigned          XLEN     = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0]      RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req_valid,
  output logic [XLEN-1:0]  mem_req_addr,
  input  logic             mem_req_ready,
  input  logic             mem_rsp_valid,
  input  logic [XLEN-1:0]  mem_rsp_data,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             inst_valid,
  output logic [XLEN-1:0]  inst_data,
  output logic [XLEN-1:0]  inst_pc,
  input  logic             inst_ready
);

  import fetch_pkg::*;

  localparam int unsigned     CW         = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(ILEN_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q;
  logic [XLEN-1:0] rsp_pc_d;
  logic [CW-1:0]   outstanding_q;
  logic [CW-1:0]   outstanding_d;
  logic [CW-1:0]   drop_cnt_q;
  logic [CW-1:0]   drop_cnt_d;
  logic            req_valid_q;
  logic            req_valid_d;

  logic            req_fire_s;
  logic            rsp_ok_s;
  logic            push_s;
  logic            pop_s;
  logic            flush_s;
  logic [CW-1:0]   occ_next_s;
  logic [CW-1:0]   fifo_count_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  fetch_entry_t    push_entry_s;
  fetch_entry_t    head_s;

  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = fetch_pc_q;
  assign inst_valid    = ~fifo_empty_s;
  assign inst_data     = head_s.data;
  assign inst_pc       = head_s.pc;

  // Issue, response and redirect bookkeeping. The next request valid is
  // computed from next-cycle occupancy and outstanding count so that a
  // request can only be offered when the FIFO is guaranteed to have room.
  always_comb begin
    req_fire_s        = req_valid_q & mem_req_ready;
    rsp_ok_s          = mem_rsp_valid & (outstanding_q != {CW{1'b0}});
    pop_s             = inst_ready & ~fifo_empty_s;
    push_s            = 1'b0;
    flush_s           = 1'b0;
    fetch_pc_d        = fetch_pc_q;
    rsp_pc_d          = rsp_pc_q;
    drop_cnt_d        = drop_cnt_q;
    push_entry_s.data = mem_rsp_data;
    push_entry_s.pc   = rsp_pc_q;
    outstanding_d     = outstanding_q + CW'(req_fire_s) - CW'(rsp_ok_s);
    if (redirect_valid) begin
      // Everything still in flight after this edge belongs to the old path.
      flush_s    = 1'b1;
      drop_cnt_d = outstanding_d;
      fetch_pc_d = redirect_pc & ALIGN_MASK;
      rsp_pc_d   = redirect_pc & ALIGN_MASK;
    end else begin
      if (req_fire_s) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (rsp_ok_s && (drop_cnt_q != {CW{1'b0}})) begin
        drop_cnt_d = drop_cnt_q - CW'(1'b1);
      end else if (rsp_ok_s) begin
        push_s   = 1'b1;
        rsp_pc_d = rsp_pc_q + PC_STEP;
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end
    if (flush_s) begin
      occ_next_s = {CW{1'b0}};
    end else begin
      occ_next_s = fifo_count_s + CW'(push_s) - CW'(pop_s);
    end
    req_valid_d = ({1'b0, occ_next_s} + {1'b0, outstanding_d}) < (CW+1)'(DEPTH);
  end

  // Fetch state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= {CW{1'b0}};
      drop_cnt_q    <= {CW{1'b0}};
      req_valid_q   <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      req_valid_q   <= req_valid_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .flush      (flush_s),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s),
    .count      (fifo_count_s),
    .head       (head_s)
  );

  inst_fetch_queue_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .clk           (clk),
    .rst           (rst),
    .mem_rsp_valid (mem_rsp_valid),
    .push          (push_s),
    .pop           (pop_s),
    .fifo_full     (fifo_full_s),
    .outstanding   (outstanding_q),
    .drop_cnt      (drop_cnt_q),
    .occupancy     (fifo_count_s)
  );

endmodule
